gyro_stream_sequencer: RTL and testbench



---
 rtl/gyro_stream_sequencer.sv | 137 +++++++++++++
 tb/tb_gyro_stream_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gyro_stream_sequencer.sv
// Round-robin merge of NUM_CH sample streams into one framed AXI-Stream (TUSER = channel, TLAST = frame end).
// One-cycle latency through a single output register; a stalled output blocks every input; stop drains to the frame boundary.
module gyro_stream_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 3
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         cfg_enable,
  input  logic [7:0]                   cfg_frame_len,
  input  logic [NUM_CH-1:0]            cfg_ch_mask,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  output logic [NUM_CH-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [1:0]                   m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         busy,
  output logic [15:0]                  stat_frames
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [7:0]            last_idx;
  logic [7:0]            cnt;
  logic [7:0]            cnt_nxt;
  logic [NUM_CH-1:0]     mask_q;
  logic [NUM_CH-1:0]     elig;
  logic [1:0]            ptr;
  logic [1:0]            ptr_nxt;
  logic [1:0]            grant_idx;
  logic                  grant_found;
  logic [DATA_WIDTH-1:0] grant_dat;
  logic                  gate;
  logic                  can_load;
  logic                  load;
  logic                  load_last;
  logic                  out_acc;
  logic                  start;

  // First eligible channel at or after the pointer, wrapping modulo NUM_CH.
  always_comb begin
    elig        = s_axis_tvalid & mask_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!grant_found && elig[c] && (((int'(ptr) + i) % NUM_CH) == c)) begin
          grant_found = 1'b1;
          grant_idx   = 2'(c);
        end
      end
    end
  end

  always_comb begin
    grant_dat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_idx == 2'(c)) begin
        grant_dat = s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Once the TLAST beat of a draining frame is loaded, nothing more may enter.
  assign gate      = (state == ST_RUN) || ((state == ST_STOP) && (cnt != 8'd0));
  assign can_load  = !m_axis_tvalid || m_axis_tready;
  assign load      = gate && can_load && grant_found;
  assign load_last = (cnt == last_idx);
  assign out_acc   = m_axis_tvalid && m_axis_tready;
  assign cnt_nxt   = !load ? cnt : (load_last ? 8'd0 : cnt + 8'd1);
  assign ptr_nxt   = (grant_idx == 2'(NUM_CH - 1)) ? 2'd0 : grant_idx + 2'd1;
  assign start     = (state == ST_IDLE) && cfg_enable && (|cfg_ch_mask);

  always_comb begin
    s_axis_tready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s_axis_tready[c] = load && (grant_idx == 2'(c));
    end
  end

  // The RUN exit looks at the post-load count so a beat taken in the exit cycle still gets its frame finished.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (!cfg_enable) state_nxt = (cnt_nxt != 8'd0) ? ST_STOP : ST_IDLE;
      ST_STOP: if (out_acc && m_axis_tlast) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      last_idx      <= 8'd0;
      mask_q        <= '0;
      cnt           <= 8'd0;
      ptr           <= 2'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 2'd0;
      m_axis_tlast  <= 1'b0;
      stat_frames   <= 16'd0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      if (start) begin
        // A frame length of 0 wraps to index 255, i.e. 256 samples.
        last_idx <= cfg_frame_len - 8'd1;
        mask_q   <= cfg_ch_mask;
        cnt      <= 8'd0;
        ptr      <= 2'd0;
      end else begin
        cnt <= cnt_nxt;
        if (load) ptr <= ptr_nxt;
      end
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= grant_dat;
        m_axis_tuser  <= grant_idx;
        m_axis_tlast  <= load_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (out_acc && m_axis_tlast) stat_frames <= stat_frames + 16'd1;
    end
  end

endmodule

// File: tb/tb_gyro_stream_sequencer.sv
// Randomized and directed bench for gyro_stream_sequencer against a frame-level reference model and scoreboard.
`timescale 1ns/1ps
module tb_gyro_stream_sequencer;

  localparam int DW     = 32;
  localparam int NCH    = 3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic              cfg_enable = 1'b0;
  logic [7:0]        cfg_frame_len = 8'd0;
  logic [NCH-1:0]    cfg_ch_mask = '0;
  logic [NCH*DW-1:0] s_tdata = '0;
  logic [NCH-1:0]    s_tvalid = '0;
  logic [NCH-1:0]    s_tready;
  logic [DW-1:0]     m_tdata;
  logic [1:0]        m_tuser;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic              busy;
  logic [15:0]       stat_frames;

  always #5 ACLK = ~ACLK;

  gyro_stream_sequencer #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_enable    (cfg_enable),
    .cfg_frame_len (cfg_frame_len),
    .cfg_ch_mask   (cfg_ch_mask),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .busy          (busy),
    .stat_frames   (stat_frames)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Reference model: run mode, position inside the frame, round-robin pointer, pending output beat.
  int          md = M_IDLE;
  int          pos = 0;
  int          len = 1;
  int          ptr_m = 0;
  logic [2:0]  mask_m = '0;
  bit          ob_v = 1'b0;
  logic [31:0] ob_d = '0;
  int          ob_u = 0;
  bit          ob_l = 1'b0;
  int          frames = 0;
  bit          busy_m = 1'b0;

  int          acc_user[$];
  bit          acc_last[$];
  int          acc_cyc[$];
  logic [33:0] sbq[$];
  int          n_in_hs = 0;
  int          n_last = 0;
  int          cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL timeout_%s: got no event want event within bound", nm);
  endtask

  task automatic model_reset();
    md = M_IDLE; pos = 0; ptr_m = 0; mask_m = '0;
    ob_v = 1'b0; ob_d = '0; ob_u = 0; ob_l = 1'b0;
    frames = 0; busy_m = 1'b0;
    sbq.delete();
  endtask

  task automatic check_cycle();
    bit gate, canl, found, ld, acc, acc_tl;
    int k, idx;
    logic [NCH-1:0] exp_rdy;
    logic [33:0] e;
    gate = (md == M_RUN) || (md == M_STOP && pos != 0);
    canl = !ob_v || m_tready;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (ptr_m + i) % NCH;
      if (!found && s_tvalid[idx] && mask_m[idx]) begin
        found = 1'b1;
        k = idx;
      end
    end
    ld = gate && canl && found;
    exp_rdy = '0;
    if (ld) exp_rdy[k] = 1'b1;

    chk("s_axis_tready", s_tready, exp_rdy);
    chk("m_axis_tvalid", m_tvalid, ob_v);
    chk("busy", busy, busy_m);
    chk("stat_frames", stat_frames, frames[15:0]);
    if (ob_v) begin
      chk("m_axis_tdata", m_tdata, ob_d);
      chk("m_axis_tuser", m_tuser, ob_u);
      chk("m_axis_tlast", m_tlast, ob_l);
    end

    // Order scoreboard: every delivered beat must be the oldest accepted sample not yet delivered.
    if (m_tvalid && m_tready) begin
      acc_user.push_back(int'(m_tuser));
      acc_last.push_back(m_tlast);
      acc_cyc.push_back(cyc);
      if (m_tlast) n_last++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: got beat %0h want no beat (cycle %0d)", m_tdata, cyc);
      end else begin
        e = sbq.pop_front();
        chk("scoreboard", {m_tuser, m_tdata}, e);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (s_tvalid[c] && s_tready[c]) begin
        sbq.push_back({2'(c), s_tdata[c*DW +: DW]});
        n_in_hs++;
      end
    end

    if (ARESET) begin
      model_reset();
    end else begin
      acc    = ob_v && m_tready;
      acc_tl = acc && ob_l;
      if (acc_tl) frames++;
      if (ld) begin
        ob_v  = 1'b1;
        ob_d  = s_tdata[k*DW +: DW];
        ob_u  = k;
        ob_l  = (pos == len - 1);
        pos   = ob_l ? 0 : pos + 1;
        ptr_m = (k + 1) % NCH;
      end else if (acc) begin
        ob_v = 1'b0;
      end
      case (md)
        M_IDLE: if (cfg_enable && cfg_ch_mask != 0) begin
          md     = M_RUN;
          len    = (cfg_frame_len == 0) ? 256 : int'(cfg_frame_len);
          mask_m = cfg_ch_mask;
          pos    = 0;
          ptr_m  = 0;
        end
        M_RUN:  if (!cfg_enable) md = (pos != 0) ? M_STOP : M_IDLE;
        M_STOP: if (acc_tl) md = M_IDLE;
        default: md = M_IDLE;
      endcase
      busy_m = (md != M_IDLE);
    end
    cyc++;
  endtask

  always @(negedge ACLK) s_tdata = {$urandom(), $urandom(), $urandom()};

  always @(negedge ACLK) begin
    #2;
    if (chk_on) check_cycle();
  end

  task automatic clear_log();
    acc_user.delete();
    acc_last.delete();
    acc_cyc.delete();
    n_in_hs = 0;
    n_last  = 0;
  endtask

  task automatic pulse(input logic [7:0] fl, input logic [2:0] mk);
    cfg_frame_len = fl;
    cfg_ch_mask   = mk;
    cfg_enable    = 1'b1;
    @(negedge ACLK);
    cfg_enable = 1'b0;
  endtask

  task automatic wait_quiet(input int max, input string nm);
    int n = 0;
    while ((busy !== 1'b0 || m_tvalid !== 1'b0) && n < max) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= max) timeout_fail(nm);
    @(negedge ACLK);
  endtask

  task automatic wait_hs(input int target, input int max, input string nm);
    int n = 0;
    while (n_in_hs < target && n < max) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= max) timeout_fail(nm);
  endtask

  task automatic wait_last(input int target, input int max, input string nm);
    int n = 0;
    while (n_last < target && n < max) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= max) timeout_fail(nm);
  endtask

  // Expected channel of beat i is (i % md_) * mul.
  task automatic chk_frame(input string nm, input int n, input int md_, input int mul);
    chk({nm, "_beats"}, acc_user.size(), n);
    for (int i = 0; i < n && i < acc_user.size(); i++) begin
      chk({nm, "_tuser"}, acc_user[i], (i % md_) * mul);
      chk({nm, "_tlast"}, acc_last[i], (i == n - 1));
    end
  endtask

  initial begin
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk_on = 1'b1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stat", stat_frames, 0);
    chk("rst_tready", s_tready, 0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // One frame of 6 over all three channels at full rate.
    clear_log();
    s_tvalid = 3'b111;
    m_tready = 1'b1;
    pulse(8'd6, 3'b111);
    wait_quiet(40, "b");
    chk_frame("b", 6, 3, 1);
    if (acc_cyc.size() == 6) chk("b_rate", acc_cyc[5] - acc_cyc[0], 5);
    chk("b_stat", stat_frames, 1);

    // Channel 1 valid but masked off.
    clear_log();
    pulse(8'd4, 3'b101);
    wait_quiet(40, "c");
    chk_frame("c", 4, 2, 2);
    chk("c_stat", stat_frames, 2);

    // Only channel 2 first, then channel 0: pointer wraps.
    clear_log();
    s_tvalid = 3'b100;
    pulse(8'd2, 3'b111);
    wait_hs(1, 20, "d");
    s_tvalid = 3'b001;
    wait_quiet(40, "d");
    chk("d_beats", acc_user.size(), 2);
    if (acc_user.size() >= 2) begin
      chk("d_first", acc_user[0], 2);
      chk("d_second", acc_user[1], 0);
      chk("d_last", acc_last[1], 1);
    end

    // Drop enable mid-frame: the frame of 4 still completes.
    clear_log();
    s_tvalid      = 3'b111;
    cfg_frame_len = 8'd4;
    cfg_ch_mask   = 3'b111;
    cfg_enable    = 1'b1;
    wait_hs(2, 20, "e");
    cfg_enable = 1'b0;
    wait_quiet(40, "e");
    repeat (4) @(negedge ACLK);
    chk_frame("e", 4, 3, 1);
    chk("e_no_more_hs", n_in_hs, 4);

    // Five stall cycles mid-frame.
    clear_log();
    pulse(8'd6, 3'b111);
    wait_hs(3, 20, "f");
    m_tready = 1'b0;
    repeat (5) @(negedge ACLK);
    m_tready = 1'b1;
    wait_quiet(40, "f");
    chk_frame("f", 6, 3, 1);
    chk("f_in_hs", n_in_hs, 6);

    // Frame length 0 means 256 samples.
    clear_log();
    pulse(8'd0, 3'b111);
    wait_quiet(600, "g");
    chk("g_beats", acc_user.size(), 256);
    if (acc_user.size() == 256) begin
      chk("g_last_255", acc_last[255], 1);
      chk("g_last_254", acc_last[254], 0);
    end
    chk("g_frames", n_last, 1);

    // Random traffic, configuration churn and backpressure.
    for (int t = 0; t < 3000; t++) begin
      s_tvalid = 3'($urandom_range(0, 7));
      m_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) cfg_enable = !cfg_enable;
      if ($urandom_range(0, 29) == 0) cfg_ch_mask = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) cfg_frame_len = 8'($urandom_range(0, 9));
      @(negedge ACLK);
    end
    cfg_enable = 1'b0;
    s_tvalid   = 3'b111;
    m_tready   = 1'b1;
    wait_quiet(1000, "h");

    // Reset in the middle of a frame.
    clear_log();
    pulse(8'd6, 3'b111);
    wait_hs(3, 20, "j");
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("j_tvalid", m_tvalid, 0);
    chk("j_tdata", m_tdata, 0);
    chk("j_tuser", m_tuser, 0);
    chk("j_tlast", m_tlast, 0);
    chk("j_busy", busy, 0);
    chk("j_stat", stat_frames, 0);
    chk("j_tready", s_tready, 0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // 65536 single-beat frames wrap the frame counter.
    clear_log();
    cfg_frame_len = 8'd1;
    cfg_ch_mask   = 3'b111;
    s_tvalid      = 3'b111;
    m_tready      = 1'b1;
    cfg_enable    = 1'b1;
    wait_last(65535, 70000, "wrap_a");
    chk("wrap_ffff", stat_frames, 16'hFFFF);
    wait_last(65536, 10, "wrap_b");
    chk("wrap_zero", stat_frames, 16'h0000);
    cfg_enable = 1'b0;
    wait_quiet(20, "wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
